addsub_rr_scheduler: RTL and testbench

//  Shares one WIDTH-bit adder-subtractor datapath between two requesters.

---
 rtl/addsub_rr_scheduler.sv | 153 +++++++++++++++
 tb/tb_addsub_rr_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_scheduler.sv
// Round-robin arbiter in front of one shared WIDTH-bit adder-subtractor.
// Two valid/ready requesters feed a single registered, backpressured response port.
module addsub_rr_scheduler #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic [15:0]      op_count
);

  localparam int unsigned HALF = WIDTH / 2;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      count_q, count_d;

  logic             slot_free;
  logic             grant0, grant1;
  logic             xfer;

  logic [WIDTH-1:0] sel_a, sel_b, b_x, sum;
  logic             sel_sub;
  logic [HALF:0]    lo_sum, hi_sum;
  logic             sum_carry, sum_ovf, msb_cin;

  // Arbitration: on a tie the requester that was not served last wins.
  always_comb begin
    grant1     = req1_valid & (~req0_valid | ~last_q);
    grant0     = req0_valid & ~grant1;
    slot_free  = ~rsp_valid | rsp_ready;
    req0_ready = slot_free & grant0;
    req1_ready = slot_free & grant1;
    xfer       = req0_ready | req1_ready;
  end

  always_comb begin
    sel_a   = grant1 ? req1_a   : req0_a;
    sel_b   = grant1 ? req1_b   : req0_b;
    sel_sub = grant1 ? req1_sub : req0_sub;
  end

  // Two half-width adders; lower half carry-out ripples into the upper half.
  always_comb begin
    b_x       = sel_b ^ {WIDTH{sel_sub}};
    lo_sum    = {1'b0, sel_a[HALF-1:0]} + {1'b0, b_x[HALF-1:0]} + {{HALF{1'b0}}, sel_sub};
    hi_sum    = {1'b0, sel_a[WIDTH-1:HALF]} + {1'b0, b_x[WIDTH-1:HALF]}
              + {{HALF{1'b0}}, lo_sum[HALF]};
    sum       = {hi_sum[HALF-1:0], lo_sum[HALF-1:0]};
    sum_carry = hi_sum[HALF];
    // Carry into the MSB recovered from the MSB sum bit.
    msb_cin   = sel_a[WIDTH-1] ^ b_x[WIDTH-1] ^ sum[WIDTH-1];
    sum_ovf   = sum_carry ^ msb_cin;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (xfer) state_d = StFull;
      end
      StFull: begin
        if (!xfer && rsp_ready) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  // FSM outputs
  always_comb begin
    rsp_valid = (state_q == StFull);
  end

  // Response payload, pointer and counter next state
  always_comb begin
    last_d   = last_q;
    id_d     = id_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    if (xfer) begin
      last_d   = grant1;
      id_d     = grant1;
      result_d = sum;
      carry_d  = sum_carry;
      ovf_d    = sum_ovf;
      count_d  = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      last_q   <= last_d;
      id_q     <= id_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
    end
  end

  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign rsp_ovf    = ovf_q;
  assign op_count   = count_q;

  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result) && $stable(rsp_id)));

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Scoreboard bench for addsub_rr_scheduler: directed corners plus randomized traffic.
module tb_addsub_rr_scheduler;

  localparam int unsigned W = 32;

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, req0_sub;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_ovf;
  logic [W-1:0] rsp_result;
  logic [15:0]  op_count;

  addsub_rr_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .op_count(op_count)
  );

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic         pv[2];
  logic [W-1:0] pa[2], pb[2];
  logic         ps[2];
  logic         rr;
  logic         last_m;
  logic [15:0]  count_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic and signed-range reasoning.
  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub);
    exp_t       e;
    logic [W:0] full;
    e.id = id;
    if (sub) begin
      e.res = a - b;
      e.c   = (a >= b);
      e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    end else begin
      full  = {1'b0, a} + {1'b0, b};
      e.res = full[W-1:0];
      e.c   = full[W];
      e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] corners [5];
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // One clock: drive after the edge, predict handshakes at the falling edge.
  task automatic cycle();
    logic free, g0, g1;
    @(posedge clk);
    #1;
    req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_sub = ps[0];
    req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_sub = ps[1];
    rsp_ready  = rr;
    @(negedge clk);
    free = (sb.size() == 0) || rr;
    g0   = free && pv[0] && (!pv[1] || last_m == 1'b1);
    g1   = free && pv[1] && (!pv[0] || last_m == 1'b0);
    check("occupancy", rsp_valid, sb.size() != 0);
    check("req0_ready", req0_ready, g0);
    check("req1_ready", req1_ready, g1);
    check("op_count", op_count, count_m);
    if (g0 || g1) begin
      sb.push_back(model(g1, pa[g1], pb[g1], ps[g1]));
      last_m  = g1;
      count_m = count_m + 16'd1;
      pv[g1]  = 1'b0;
    end
  endtask

  task automatic set_op(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub);
    pv[n] = 1'b1; pa[n] = a; pb[n] = b; ps[n] = sub;
  endtask

  task automatic directed(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] xr, input logic xc,
                          input logic xv);
    pv[0] = 1'b0; pv[1] = 1'b0;
    set_op(n, a, b, sub);
    rr = 1'b1;
    cycle();
    check("accepted", pv[n], 1'b0);
    pv[n] = 1'b0;
    cycle();
    check("dir_valid", rsp_valid, 1'b1);
    check("dir_id", rsp_id, n[0]);
    check("dir_result", rsp_result, xr);
    check("dir_carry", rsp_carry, xc);
    check("dir_ovf", rsp_ovf, xv);
  endtask

  // Monitor: compares the presented response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && rsp_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got id=%0d result=%0h want none", rsp_id, rsp_result);
        end else begin
          e = sb[0];
          total++;
          if ({rsp_id, rsp_result, rsp_carry, rsp_ovf} !== e) begin
            bad++;
            $display("FAIL rsp: got id=%0d res=%0h c=%0d v=%0d want id=%0d res=%0h c=%0d v=%0d",
                     rsp_id, rsp_result, rsp_carry, rsp_ovf, e.id, e.res, e.c, e.v);
          end
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int start;
    rst_n = 1'b0; rr = 1'b0; last_m = 1'b1; count_m = 16'd0;
    for (int n = 0; n < 2; n++) begin
      pv[n] = 1'b0; pa[n] = '0; pb[n] = '0; ps[n] = 1'b0;
    end
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_rdy", {req0_ready, req1_ready}, 2'b00);
    check("rst_count", op_count, 16'd0);
    check("rst_result", rsp_result, 32'h0);
    check("rst_flags", {rsp_id, rsp_carry, rsp_ovf}, 3'b000);
    rst_n = 1'b1;

    // Basic add and subtract
    directed(0, 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0);
    directed(0, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Both requesters saturated: one grant per cycle
    cycle();
    start = count_m;
    set_op(0, $urandom, $urandom, 1'b0);
    set_op(1, $urandom, $urandom, 1'b1);
    rr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      for (int n = 0; n < 2; n++) if (!pv[n]) set_op(n, $urandom, $urandom, $urandom_range(0, 1));
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    cycle();
    check("tput_count", op_count, start + 6);
    cycle();

    // Stall: response held, nothing accepted, then the other requester wins
    set_op(0, 32'd10, 32'd20, 1'b0);
    cycle();
    set_op(0, 32'd1, 32'd2, 1'b0);
    set_op(1, 32'd3, 32'd4, 1'b1);
    rr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_rdy", {req0_ready, req1_ready}, 2'b00);
      check("stall_result", rsp_result, 32'd30);
    end
    rr = 1'b1;
    cycle();
    check("stall_rr", req1_ready, 1'b1);
    pv[0] = 1'b0; pv[1] = 1'b0;
    cycle();
    cycle();

    // Overflow corners
    directed(1, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed(0, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0);
    directed(0, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0, 1'b1, 1'b0);
    cycle();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      for (int n = 0; n < 2; n++)
        if (!pv[n] && $urandom_range(0, 3) != 0)
          set_op(n, rand_operand(), rand_operand(), $urandom_range(0, 1));
      rr = ($urandom_range(0, 3) != 0);
      cycle();
    end
    pv[0] = 1'b0; pv[1] = 1'b0; rr = 1'b1;
    repeat (3) cycle();
    check("drained", sb.size(), 0);

    // Asynchronous reset while a response is stalled
    set_op(0, 32'd7, 32'd9, 1'b0);
    rr = 1'b0;
    cycle();
    cycle();
    check("pre_rst_valid", rsp_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", rsp_valid, 1'b0);
    sb.delete();
    last_m = 1'b1; count_m = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    set_op(0, 32'd100, 32'd1, 1'b1);
    set_op(1, 32'd200, 32'd2, 1'b0);
    rr = 1'b1;
    cycle();
    check("rst_first_grant", req0_ready, 1'b1);
    cycle();
    pv[0] = 1'b0; pv[1] = 1'b0;
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
